// File: rtl/async_up_down.sv
`default_nettype none
// ============================================================================
// Module   : async_up_down (with jk_ff stage)
// Brief    : 3-stage ripple up/down counter built from falling-edge JK flops.
// Revision : 1.0
// ============================================================================

module jk_ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_j,
    input  logic i_k,
    output logic o_q,
    output logic o_qbar
);

    logic r_q;

    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= 1'b0;
        end else begin
            case ({i_j, i_k})
                2'b00:   r_q <= r_q;
                2'b01:   r_q <= 1'b0;
                2'b10:   r_q <= 1'b1;
                default: r_q <= ~r_q;
            endcase
        end
    end

    assign o_q    = r_q;
    assign o_qbar = ~r_q;

endmodule

module async_up_down (
    input  logic clk,
    input  logic j1,
    input  logic k1,
    input  logic j2,
    input  logic k2,
    input  logic j3,
    input  logic k3,
    input  logic m,
    output logic q1,
    output logic q2,
    output logic q3,
    output logic q1bar,
    output logic q2bar,
    output logic q3bar,
    input  logic rst_n
);

    logic w_clk2;
    logic w_clk3;

    // Up mode ripples on q falling, down mode on qbar falling; a change of m
    // that drops the mux output is intentionally seen as an active edge.
    assign w_clk2 = m ? q1 : q1bar;
    assign w_clk3 = m ? q2 : q2bar;

    jk_ff u_stage1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_j     (j1),
        .i_k     (k1),
        .o_q     (q1),
        .o_qbar  (q1bar)
    );

    jk_ff u_stage2 (
        .i_clk   (w_clk2),
        .i_rst_n (rst_n),
        .i_j     (j2),
        .i_k     (k2),
        .o_q     (q2),
        .o_qbar  (q2bar)
    );

    jk_ff u_stage3 (
        .i_clk   (w_clk3),
        .i_rst_n (rst_n),
        .i_j     (j3),
        .i_k     (k3),
        .o_q     (q3),
        .o_qbar  (q3bar)
    );

endmodule

`default_nettype wire

// File: tb/tb_async_up_down.sv
`default_nettype none
// ============================================================================
// Module   : tb_async_up_down
// Brief    : Table-driven, scoreboarded bench for the ripple up/down counter.
// Revision : 1.0
// ============================================================================

module tb_async_up_down;

    logic clk;
    logic rst_n;
    logic j1, k1, j2, k2, j3, k3, m;
    logic q1, q2, q3, q1bar, q2bar, q3bar;

    async_up_down dut (
        .clk   (clk),
        .j1    (j1),
        .k1    (k1),
        .j2    (j2),
        .k2    (k2),
        .j3    (j3),
        .k3    (k3),
        .m     (m),
        .q1    (q1),
        .q2    (q2),
        .q3    (q3),
        .q1bar (q1bar),
        .q2bar (q2bar),
        .q3bar (q3bar),
        .rst_n (rst_n)
    );

    // Falling edges at 10, 30, 50 ...; rising edges at 20, 40 ...
    initial begin
        clk = 1'b1;
        forever #10 clk = ~clk;
    end

    typedef struct {
        logic       rst;   // pulse reset (and set m) before this step
        logic [5:0] jk;    // {j1,k1,j2,k2,j3,k3}
        logic       m;
        logic [2:0] exp;   // {q3,q2,q1} after the falling edge
    } vec_t;

    vec_t       vecs[$];
    logic [2:0] sb[$];
    int         n_cmp;
    int         n_err;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_state(input string name, input logic [2:0] req);
        check(name, {q3, q2, q1}, req);
        check({name, "_bar"}, {q3bar, q2bar, q1bar}, ~req);
    endtask

    task automatic drive(input logic [5:0] jk, input logic mode);
        {j1, k1, j2, k2, j3, k3} = jk;
        m = mode;
    endtask

    // Called at posedge+1: reset, settle mode under reset, release after one falling edge.
    task automatic pulse_reset(input logic [5:0] jk, input logic mode);
        rst_n = 1'b0;
        drive(jk, mode);
        #1;
        check_state("rst_immediate", 3'b000);
        @(negedge clk); #1;
        check_state("rst_held", 3'b000);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic step(input logic [2:0] exp);
        logic [2:0] req;
        sb.push_back(exp);
        @(negedge clk); #1;
        req = sb.pop_front();
        check_state("count", req);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(6'b111111, 1'b1);
        #1;
        check_state("reset_state", 3'b000);

        // Up count with wrap.
        vecs.push_back('{1'b1, 6'b111111, 1'b1, 3'd1});
        for (int i = 2; i <= 8; i++) vecs.push_back('{1'b0, 6'b111111, 1'b1, 3'(i % 8)});
        // Down count with wrap.
        vecs.push_back('{1'b1, 6'b111111, 1'b0, 3'd7});
        for (int i = 6; i >= 0; i--) vecs.push_back('{1'b0, 6'b111111, 1'b0, 3'(i)});
        // Count to 3, then freeze with j1=k1=0.
        vecs.push_back('{1'b1, 6'b111111, 1'b1, 3'd1});
        vecs.push_back('{1'b0, 6'b111111, 1'b1, 3'd2});
        vecs.push_back('{1'b0, 6'b111111, 1'b1, 3'd3});
        for (int i = 0; i < 3; i++) vecs.push_back('{1'b0, 6'b001111, 1'b1, 3'd3});
        // Set stage 1, hold, then reset it; upper stages hold.
        vecs.push_back('{1'b1, 6'b100000, 1'b1, 3'd1});
        vecs.push_back('{1'b0, 6'b100000, 1'b1, 3'd1});
        vecs.push_back('{1'b0, 6'b100000, 1'b1, 3'd1});
        vecs.push_back('{1'b0, 6'b010000, 1'b1, 3'd0});
        // Up mode with stage 2 forced to 0 by J=0,K=1.
        vecs.push_back('{1'b1, 6'b110100, 1'b1, 3'd1});
        vecs.push_back('{1'b0, 6'b110100, 1'b1, 3'd0});
        vecs.push_back('{1'b0, 6'b110100, 1'b1, 3'd1});
        vecs.push_back('{1'b0, 6'b110100, 1'b1, 3'd0});
        // Down mode with stage 2 set by J=1,K=0 on q1bar falling; stage 3 held.
        vecs.push_back('{1'b1, 6'b111000, 1'b0, 3'd3});
        vecs.push_back('{1'b0, 6'b111000, 1'b0, 3'd2});
        vecs.push_back('{1'b0, 6'b111000, 1'b0, 3'd3});
        vecs.push_back('{1'b0, 6'b111000, 1'b0, 3'd2});

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            if (vecs[i].rst) pulse_reset(vecs[i].jk, vecs[i].m);
            else             drive(vecs[i].jk, vecs[i].m);
            step(vecs[i].exp);
        end

        // Count to 101, rising edge has no effect, then reset mid-count.
        @(posedge clk); #1;
        pulse_reset(6'b111111, 1'b1);
        for (int i = 1; i <= 5; i++) step(3'(i));
        @(posedge clk); #1;
        check_state("rise_no_effect", 3'b101);
        rst_n = 1'b0;
        #1;
        check_state("mid_reset", 3'b000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check_state("reset_hold", 3'b000);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(3'd1);
        step(3'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
